// File: rtl/nanorv32_apb_master_if.sv
// Host request/response port and APB3 bus of the nanorv32 peripheral bridge.
// The master modport is the bridge's view; the slave modport is the host/peripheral side.
interface nanorv32_apb_master_if #(
  parameter int NSLV = 4
);
  logic                 host_req;
  logic                 host_gnt;
  logic [31:0]          host_addr;
  logic                 host_we;
  logic [31:0]          host_wdata;
  logic                 host_rvalid;
  logic [31:0]          host_rdata;
  logic                 host_err;

  logic [NSLV-1:0]      apb_psel;
  logic                 apb_penable;
  logic                 apb_pwrite;
  logic [11:0]          apb_paddr;
  logic [31:0]          apb_pwdata;
  logic [NSLV*32-1:0]   apb_prdata_all;
  logic [NSLV-1:0]      apb_pready_all;
  logic [NSLV-1:0]      apb_pslverr_all;

  modport master (
    input  host_req, host_addr, host_we, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  apb_prdata_all, apb_pready_all, apb_pslverr_all
  );

  modport slave (
    output host_req, host_addr, host_we, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output apb_prdata_all, apb_pready_all, apb_pslverr_all
  );
endinterface

// File: rtl/nanorv32_apb_master.sv
// APB3 bridge for the nanorv32 peripheral port: decodes the slave from address bits,
// runs SETUP/ACCESS, and returns read data plus an error flag (decode error, pslverr or timeout).
module nanorv32_apb_master #(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nanorv32_apb_master_if.master bus
);

  localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [SEL_W:0]    NSLV_LIM  = (SEL_W + 1)'(NSLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t            state;
  logic [NSLV-1:0]   psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [11:0]       paddr_q;
  logic [31:0]       pwdata_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  logic [SEL_W-1:0]  sel_field;
  logic              sel_ok;
  logic [NSLV-1:0]   sel_onehot;
  logic [31:0]       sel_rdata;
  logic              sel_ready;
  logic              sel_err;
  logic              timed_out;
  logic              unused_addr;

  assign sel_field    = bus.host_addr[SEL_LSB +: SEL_W];
  assign sel_ok       = {1'b0, sel_field} < NSLV_LIM;
  assign timed_out    = (TIMEOUT != 0) && (cnt == CNT_LIMIT);
  assign bus.host_gnt = bus.host_req && (state == IDLE);
  // Address bits outside the page offset and the select field carry no meaning here.
  assign unused_addr  = ^bus.host_addr;

  // The latched one-hot psel both drives the bus and steers the response mux,
  // so responses from unselected slaves can never leak through.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    sel_onehot = '0;
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      sel_onehot[i] = (sel_field == SEL_W'(i));
      if (psel_q[i]) begin
        sel_rdata = sel_rdata | bus.apb_prdata_all[32*i +: 32];
        sel_ready = sel_ready | bus.apb_pready_all[i];
        sel_err   = sel_err   | bus.apb_pslverr_all[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.host_req) begin
            if (sel_ok) begin
              psel_q   <= sel_onehot;
              paddr_q  <= bus.host_addr[11:0];
              pwrite_q <= bus.host_we;
              pwdata_q <= bus.host_wdata;
              state    <= SETUP;
            end else begin
              state <= DERR;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout reached in the same cycle.
          if (sel_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= pwrite_q ? 32'h0 : sel_rdata;
            err_q     <= sel_err;
            state     <= IDLE;
          end else if (timed_out) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            state     <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DERR: begin
          rvalid_q <= 1'b1;
          rdata_q  <= '0;
          err_q    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_pwdata  = pwdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_err    = err_q;

endmodule

// File: tb/tb_nanorv32_apb_master.sv
// Directed bench for nanorv32_apb_master (TIMEOUT=4): the driver queues expected host
// responses and APB phases at grant; independent monitors pop and compare them.
module tb_nanorv32_apb_master;

  localparam int NSLV = 4;
  localparam logic [31:0] SLV0 = 32'hDEAD_BEEF;
  localparam logic [31:0] SLV1 = 32'hC0DE_0001;
  localparam logic [31:0] SLV2 = 32'h2222_2222;
  localparam logic [31:0] SLV3 = 32'h3333_3333;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanorv32_apb_master_if #(.NSLV(NSLV)) bus();

  nanorv32_apb_master #(
    .NSLV(NSLV), .SEL_LSB(12), .SEL_W(4), .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [3:0]  psel;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  apb_t cur;
  rsp_t got;

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cfg_wait = 0;
  logic cfg_err = 1'b0;
  int   acc = 0;
  int   t1, t2;

  assign bus.apb_prdata_all = {SLV3, SLV2, SLV1, SLV0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: the selected slave raises pready after cfg_wait ACCESS cycles;
  // unselected slaves present inverted pready/pslverr that the bridge must ignore.
  always @(negedge clk) begin
    if (bus.apb_psel != '0 && bus.apb_penable) begin
      bus.apb_pready_all  = (acc == cfg_wait) ? bus.apb_psel : ~bus.apb_psel;
      bus.apb_pslverr_all = cfg_err ? bus.apb_psel : ~bus.apb_psel;
      acc++;
    end else begin
      acc = 0;
      bus.apb_pready_all  = '0;
      bus.apb_pslverr_all = '0;
    end
  end

  // Host response monitor
  always @(negedge clk) begin
    if (rst_n && bus.host_rvalid) begin
      if (rsp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid at cycle %0d, required none", cyc);
      end else begin
        got = rsp_q.pop_front();
        check("rdata", bus.host_rdata, got.rdata);
        check("err", 32'(bus.host_err), 32'(got.err));
        check("rvalid_cycle", 32'(cyc), 32'(got.due));
      end
    end
  end

  // APB phase monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("psel_onehot0", 32'($onehot0(bus.apb_psel)), 32'd1);
      check("penable_implies_psel", 32'(!bus.apb_penable || (bus.apb_psel != '0)), 32'd1);
      if (bus.apb_psel != '0 && !bus.apb_penable) begin
        if (apb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_setup: got psel %b, required no APB activity", bus.apb_psel);
        end else begin
          cur = apb_q.pop_front();
        end
      end
      if (bus.apb_psel != '0) begin
        check("psel", 32'(bus.apb_psel), 32'(cur.psel));
        check("paddr", 32'(bus.apb_paddr), 32'(cur.paddr));
        check("pwrite", 32'(bus.apb_pwrite), 32'(cur.pwrite));
        check("pwdata", bus.apb_pwdata, cur.pwdata);
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] e_psel, input logic [31:0] e_rdata, input logic e_err,
                       input int lat, input bit track, output int t_gnt);
    bit   granted;
    apb_t a;
    rsp_t r;
    granted        = 1'b0;
    t_gnt          = -1;
    bus.host_req   = 1'b1;
    bus.host_addr  = addr;
    bus.host_we    = we;
    bus.host_wdata = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.host_gnt) begin
        granted = 1'b1;
        break;
      end
    end
    if (!granted) begin
      n_vec++;
      n_fail++;
      $display("FAIL grant_timeout: got no host_gnt for addr %h, required a grant", addr);
    end else begin
      t_gnt = cyc;
      if (e_psel != '0) begin
        a.psel   = e_psel;
        a.paddr  = addr[11:0];
        a.pwrite = we;
        a.pwdata = wdata;
        apb_q.push_back(a);
      end
      if (track) begin
        r.rdata = e_rdata;
        r.err   = e_err;
        r.due   = cyc + lat;
        rsp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    // Scramble host inputs after grant: the bridge must have latched them already.
    bus.host_req   = 1'b0;
    bus.host_addr  = 32'hA5A5_3A5A;
    bus.host_we    = ~we;
    bus.host_wdata = ~wdata;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_q.size() == 0) break;
    end
    check("drain_pending", 32'(rsp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1);
  end

  initial begin
    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_we    = 1'b0;
    bus.host_wdata = '0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_psel", 32'(bus.apb_psel), 32'd0);
    check("rst_penable", 32'(bus.apb_penable), 32'd0);
    check("rst_pwrite", 32'(bus.apb_pwrite), 32'd0);
    check("rst_paddr", 32'(bus.apb_paddr), 32'd0);
    check("rst_pwdata", bus.apb_pwdata, 32'd0);
    check("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_rdata", bus.host_rdata, 32'd0);
    check("rst_err", 32'(bus.host_err), 32'd0);
    check("rst_gnt", 32'(bus.host_gnt), 32'd0);
    @(posedge clk);
    #1;

    // Zero-wait read from slave 0
    cfg_wait = 0; cfg_err = 1'b0;
    issue(32'h0000_0004, 1'b0, 32'h0, 4'b0001, SLV0, 1'b0, 3, 1'b1, t1);
    drain();

    // Write to slave 2 with three wait states
    cfg_wait = 3; cfg_err = 1'b0;
    issue(32'h0000_2010, 1'b1, 32'h1234_5678, 4'b0100, 32'h0, 1'b0, 6, 1'b1, t1);
    drain();

    // Read from slave 1 completing with pslverr
    cfg_wait = 0; cfg_err = 1'b1;
    issue(32'h0000_1008, 1'b0, 32'h0, 4'b0010, SLV1, 1'b1, 3, 1'b1, t1);
    drain();

    // Decode error: index 7
    cfg_wait = 0; cfg_err = 1'b0;
    issue(32'h0000_7000, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 2, 1'b1, t1);
    drain();

    // Hung slave 3: five ACCESS cycles then timeout
    cfg_wait = 1000; cfg_err = 1'b0;
    issue(32'h0000_3000, 1'b0, 32'h0, 4'b1000, 32'h0, 1'b1, 7, 1'b1, t1);
    drain();

    // pready arrives in the same cycle the timeout is reached
    cfg_wait = 4; cfg_err = 1'b0;
    issue(32'h0000_300C, 1'b0, 32'h0, 4'b1000, SLV3, 1'b0, 7, 1'b1, t1);
    drain();

    // Write with pslverr: rdata forced to 0
    cfg_wait = 1; cfg_err = 1'b1;
    issue(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 4'b0001, 32'h0, 1'b1, 4, 1'b1, t1);
    drain();

    // High address bits set outside the select field
    cfg_wait = 2; cfg_err = 1'b0;
    issue(32'hFFFF_1FFC, 1'b0, 32'h55AA_55AA, 4'b0010, SLV1, 1'b0, 5, 1'b1, t1);
    drain();

    // Back-to-back reads: second grant lands on the first rvalid
    cfg_wait = 0; cfg_err = 1'b0;
    issue(32'h0000_0100, 1'b0, 32'h0, 4'b0001, SLV0, 1'b0, 3, 1'b1, t1);
    issue(32'h0000_2200, 1'b0, 32'h0, 4'b0100, SLV2, 1'b0, 3, 1'b1, t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd3);
    drain();

    // Reset pulsed during ACCESS: bus drops at once and no response follows
    cfg_wait = 1000; cfg_err = 1'b0;
    issue(32'h0000_3004, 1'b0, 32'h0, 4'b1000, 32'h0, 1'b0, 0, 1'b0, t1);
    @(posedge clk);
    #2;
    check("pre_reset_penable", 32'(bus.apb_penable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_psel", 32'(bus.apb_psel), 32'd0);
    check("async_rst_penable", 32'(bus.apb_penable), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdata", bus.host_rdata, 32'd0);
    check("post_rst_err", 32'(bus.host_err), 32'd0);
    check("post_rst_paddr", 32'(bus.apb_paddr), 32'd0);
    repeat (10) @(negedge clk);

    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    check("apb_q_empty", 32'(apb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nanorv32_apb_master.md
Name: nanorv32_apb_master

Overview:
- APB3 initiator (bridge) between the nanorv32 core's peripheral data port and the APB peripherals (intc, uart, timer, gpio).
- Takes single-beat read/write requests on a simple req/gnt host port.
- Decodes the target slave from address bits, sequences the APB SETUP/ACCESS phases, and waits on pready.
- Returns read data and an error flag to the host, with a timeout so a hung slave cannot lock up the core.

Parameters:
- NSLV, 4: number of APB slaves; one psel bit per slave.
- SEL_LSB, 12: lowest host address bit of the slave-select field.
- SEL_W, 4: width of the slave-select field; indices >= NSLV are decode errors.
- TIMEOUT, 255: ACCESS cycles to wait for pready before aborting with an error; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  transfer request; held until granted
- host_gnt  out  1  request accepted this cycle (host_req & state==IDLE)
- host_addr  in  32  byte address
- host_we  in  1  1=write, 0=read
- host_wdata  in  32  write data
- host_rvalid  out  1  one-cycle completion pulse
- host_rdata  out  32  read data, valid with host_rvalid
- host_err  out  1  error flag, valid with host_rvalid
- apb_psel  out  NSLV  one-hot slave select
- apb_penable  out  1  ACCESS phase
- apb_pwrite  out  1  write control
- apb_paddr  out  12  address (host_addr[11:0])
- apb_pwdata  out  32  write data
- apb_prdata_all  in  NSLV*32  slave read data; slave i occupies [32i+31:32i]
- apb_pready_all  in  NSLV  per-slave pready
- apb_pslverr_all  in  NSLV  per-slave pslverr

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low.
  - On reset: state=IDLE.
  - All outputs 0: psel, penable, pwrite, paddr, pwdata, host_rvalid, host_rdata, host_err.
  - Reset asserted mid-transfer aborts the transfer immediately; no host_rvalid is produced for it.
- Registers: all APB outputs are registered. At grant, addr/we/wdata/select index are latched; host inputs are ignored afterwards.
- FSM states: IDLE, SETUP, ACCESS, DERR.
- IDLE:
  - host_gnt = host_req.
  - On grant with index < NSLV: go to SETUP.
  - On grant with index >= NSLV: go to DERR.
- SETUP (1 cycle): psel[idx]=1, penable=0; paddr, pwrite, pwdata driven and stable. Always goes to ACCESS.
- ACCESS: psel[idx]=1, penable=1; paddr, pwrite, pwdata held stable.
  - Completes when pready_all[idx]=1, or when the timeout counter reaches TIMEOUT (TIMEOUT != 0).
  - On completion: psel=0, penable=0 on the next edge; state returns to IDLE.
  - rdata is captured from prdata_all[idx] for reads; it is 0 for writes and for timeouts.
  - err = pslverr_all[idx] when pready, else 1 (timeout).
- DERR: no APB activity. On the next cycle: host_rvalid=1, host_err=1, host_rdata=0. Returns to IDLE.
- Response timing:
  - host_rvalid is a registered one-cycle pulse in the cycle after the completing ACCESS cycle (or DERR).
  - host_rdata and host_err hold their value until the next completion.
- Latency: grant at cycle T → SETUP T+1 → ACCESS T+2 → host_rvalid at T+3 with zero wait states; each pready-low cycle adds 1.
  - host_gnt may be asserted in the same cycle as host_rvalid (back-to-back requests). Peak rate is one transfer per 3 cycles.
- Timeout counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle with pready=0.
  - Saturates; width is clog2(TIMEOUT+1).
  - If pready and the timeout coincide in the same cycle, pready wins (normal completion).
- Unselected slaves: their pready, pslverr and prdata are ignored.
- Invariants: psel is never multi-hot; penable=1 only together with psel.

Test Plan:
- Read, slave 0, addr 0x0000_0004, pready=1 immediately, prdata0=0xDEADBEEF → psel=4'b0001; SETUP then ACCESS; host_rvalid at T+3 with rdata=0xDEADBEEF, err=0.
- Write, slave 2, addr 0x0000_2010, wdata=0x1234_5678, pready2 low 3 cycles → paddr=0x010, pwrite=1, pwdata stable through 4 ACCESS cycles; rvalid at T+6, err=0, rdata=0.
- Read, slave 1, pslverr1=1 with pready → rvalid, err=1, rdata=prdata1.
- Read, addr 0x0000_7000 (index 7 ≥ NSLV) → psel stays 0; rvalid at T+2, err=1, rdata=0.
- TIMEOUT=4, slave 3 pready held 0 → ACCESS lasts exactly 5 cycles, then rvalid, err=1, rdata=0.
- Back-to-back and reset:
  - Two reads issued back-to-back → second grant coincides with the first rvalid; transfers spaced 3 cycles apart.
  - rst_n pulsed low during ACCESS → psel/penable drop asynchronously; no rvalid follows.
